// File: rtl/int_ctrl_pkg.sv
// Shared constants and types for the interrupt controller: I/O port IDs and
// the request FSM state encoding.
package int_ctrl_pkg;

  localparam logic [7:0] MASK_ID   = 8'h83;
  localparam logic [7:0] ACK_ID    = 8'h84;
  localparam logic [7:0] STATUS_ID = 8'h86;
  localparam logic [7:0] VECTOR_ID = 8'h87;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSERT   = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

endpackage

// File: rtl/int_ctrl_if.sv
// MCU I/O bus as seen by the interrupt controller.
interface int_ctrl_if;

  // Handshake: io_strb is a single-cycle write strobe qualified by port_id; a
  // write takes effect on the CLK edge where io_strb is high (no ready/backpressure).
  // Reads are combinational: rd_hit/rd_data follow port_id in the same cycle.
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       io_strb;
  logic [7:0] rd_data;
  logic       rd_hit;

  modport master (
    output port_id, out_port, io_strb,
    input  rd_data, rd_hit
  );

  modport slave (
    input  port_id, out_port, io_strb,
    output rd_data, rd_hit
  );

endinterface

// File: rtl/int_ctrl_edge_sync.sv
// Two-flop synchronizer with rising-edge pulse for one asynchronous request line.
// A line already high when reset releases must drop before it can fire.
module edge_sync (
  input  logic CLK,
  input  logic RST_N,
  input  logic din,
  output logic pulse
);

  logic       sync1;
  logic       sync2;
  logic       prev;
  logic       armed;
  logic [1:0] fill;

  // fill marks when sync2 reflects the real input; armed needs one synced low.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
      armed <= 1'b0;
      fill  <= 2'b00;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      prev  <= sync2;
      fill  <= {fill[0], 1'b1};
      armed <= armed | (fill[1] & ~sync2);
    end
  end

  assign pulse = armed & sync2 & ~prev;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: shares the MCU interrupt input among N_SRC requesters
// with fixed priority, a stretched int_out pulse and mask/ack/status/vector ports.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int N_SRC        = 4,
  parameter int PULSE_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [N_SRC-1:0] src_req,
  int_ctrl_if.slave        bus,
  output logic             int_out,
  output state_t           state_dbg
);

  localparam int CW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

  logic [N_SRC-1:0] edges;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] ack_clr;
  logic [2:0]       active;
  logic [2:0]       enc_idx;
  logic             valid;
  logic [CW-1:0]    cnt;
  state_t           state;
  logic             ack_wr;
  logic             mask_wr;
  logic             unused_out_port;

  for (genvar i = 0; i < N_SRC; i++) begin : g_sync
    edge_sync u_sync (
      .CLK   (CLK),
      .RST_N (RST_N),
      .din   (src_req[i]),
      .pulse (edges[i])
    );
  end

  assign ack_wr   = bus.io_strb && (bus.port_id == ACK_ID);
  assign mask_wr  = bus.io_strb && (bus.port_id == MASK_ID);
  assign eligible = pending & mask;
  assign unused_out_port = &{1'b0, bus.out_port[7:N_SRC]};

  // Lowest index wins: scan downwards so the last hit is the smallest.
  always_comb begin
    enc_idx = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) enc_idx = 3'(i);
    end
  end

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (ack_wr && (state != IDLE) && (active == 3'(i))) ack_clr[i] = 1'b1;
    end
  end

  // A new edge in the same cycle as its ACK keeps pending set.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending <= '0;
      mask    <= '0;
    end else begin
      pending <= (pending & ~ack_clr) | edges;
      if (mask_wr) mask <= bus.out_port[N_SRC-1:0];
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= IDLE;
      active  <= 3'd0;
      valid   <= 1'b0;
      int_out <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (eligible != '0) begin
            active  <= enc_idx;
            valid   <= 1'b1;
            int_out <= 1'b1;
            cnt     <= CW'(PULSE_CYCLES - 1);
            state   <= ASSERT;
          end
        end
        ASSERT: begin
          if (ack_wr) begin
            int_out <= 1'b0;
            valid   <= 1'b0;
            state   <= IDLE;
          end else if (cnt == '0) begin
            int_out <= 1'b0;
            state   <= WAIT_ACK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT_ACK: begin
          if (ack_wr) begin
            valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          int_out <= 1'b0;
          valid   <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bus.rd_hit  = 1'b0;
    bus.rd_data = 8'h00;
    if (bus.port_id == STATUS_ID) begin
      bus.rd_hit  = 1'b1;
      bus.rd_data = {{(8 - N_SRC){1'b0}}, pending};
    end else if (bus.port_id == VECTOR_ID) begin
      bus.rd_hit  = 1'b1;
      bus.rd_data = {valid, 4'b0000, active};
    end
  end

  assign state_dbg = state;

endmodule
